fetch_queue: RTL
================

# fetch_queue

Parametrised fetch stage with a decoupling instruction buffer. It generates the fetch PC and talks to instruction memory over a req/ack handshake that tolerates variable latency. Fetched {PC, instruction} pairs are held in a DEPTH-entry FIFO, so decode stalls no longer freeze the PC register. Execute-stage redirects (taken branch, jump, JALR) flush the FIFO and cancel any in-flight fetch. The block sits between instruction memory and the pipeline_f_d register, replacing the bare PC/PC+4 mux path.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction width
- ADDR_WIDTH, 32, PC width
- DEPTH, 4, FIFO entries; must be a power of two, ≥2
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- redirect  in  1  execute-stage redirect (PCSrc)
- redirect_pc  in  ADDR_WIDTH  redirect target (PCTargetE); bits [1:0] ignored and forced to 0
- stall  in  1  decode not accepting the head entry this cycle
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_WIDTH  fetch address; valid while imem_req=1
- imem_ack  in  1  response valid; may be asserted in the same cycle as imem_req
- imem_rdata  in  DATA_WIDTH  instruction; valid when imem_ack=1
- instr_valid  out  1  head entry present
- InstrD  out  DATA_WIDTH  head instruction
- PCD  out  ADDR_WIDTH  head PC
- PCPlus4D  out  ADDR_WIDTH  PCD + 4, modulo 2^ADDR_WIDTH

## Operation
- State: fetch_pc register, FIFO storage, read/write pointers (log2 DEPTH bits, natural wrap), and count register ($clog2(DEPTH+1) bits).
- FSM has two states.
  - REQ: normal fetching.
  - DROP: an abandoned request is still outstanding and its response must be discarded.
- Memory contract: every cycle with imem_req=1 and imem_ack=0 commits the memory to exactly one later ack, even if req then drops. The held request must not change address.
- pop = instr_valid & ~stall & ~redirect. space = (count < DEPTH) | pop.
- REQ:
  - imem_req = space, or a request already pending. Once asserted, req is held until ack.
  - imem_addr = fetch_pc.
- REQ with ack=1 and no redirect:
  - Push {fetch_pc, imem_rdata} at the write pointer.
  - fetch_pc += 4.
- REQ with redirect and ack=1 on the same cycle: discard rdata, stay in REQ.
- REQ with redirect while a request is pending without ack: go to DROP.
- In all redirect cases:
  - Clear the FIFO: pointers and count go to 0.
  - fetch_pc ← redirect_pc.
  - pop is suppressed.
- DROP:
  - imem_req = 0.
  - On ack, discard rdata and return to REQ.
  - A redirect in DROP only updates fetch_pc again and keeps the FIFO cleared.
- Push and pop in the same cycle leave count unchanged. Overflow is impossible because of the space gating; underflow is impossible because pop requires instr_valid.
- instr_valid = (count != 0). InstrD and PCD come straight from the head entry.

## Timing
- Reset (rst=0, asynchronous):
  - fetch_pc = RESET_PC, state = REQ, count = 0, pointers = 0, all FIFO entries = 0.
  - Outputs: instr_valid=0, InstrD=0, PCD=0, PCPlus4D=4, imem_req=0.
- imem_req rises in the first cycle after rst deasserts.
- Latency: an instruction acked in cycle N is visible on InstrD with instr_valid=1 in cycle N+1.
- Zero-wait memory (imem_ack tied 1): sustains one instruction per cycle with no bubbles.
- A redirect in cycle N gives:
  - instr_valid=0 in cycle N+1;
  - imem_addr=redirect_pc in cycle N+1 if no request was pending, otherwise in the cycle after the dropped ack.
- Head outputs change only on a pop, push-into-empty, redirect or reset.
- Reset asserted mid-request abandons the request. The memory must also be reset, so no stray ack arrives.

## Test plan
1. imem_ack=1, instruction memory returns the address as data, stall=0 → from cycle 2 PCD = 0, 4, 8, … on consecutive cycles; InstrD equals PCD; instr_valid stays 1.
2. stall=1 held from reset, ack=1 → FIFO holds 0, 4, 8, 12; imem_req=0 once count=4. Release stall → pops on consecutive cycles, and req reasserts in the same cycle as the first pop.
3. Ack latency 3 cycles, stall=0 → imem_addr held for 3 cycles per fetch; instructions appear one every 3 cycles in order 0, 4, 8.
4. Redirect to 0x100 while a request to 0x10 is pending (latency 3) → FIFO empties; state DROP; the 0x10 response is discarded; next imem_addr = 0x100; next PCD = 0x100.
5. Redirect to 0x203 on the same cycle as the ack of 0x20 → 0x20 data discarded; no DROP; next cycle imem_addr = 0x200.
6. Assert rst while count=3 and a request is pending → outputs immediately at reset values. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch stage: PC generation, req/ack instruction memory port and a DEPTH-entry
// decoupling FIFO of {PC, instruction} pairs feeding decode.
//
// state | meaning
// REQ   | normal fetching; a raised request is held until its ack
// DROP  | an abandoned request is still outstanding; its response is discarded
module fetch_queue #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   input  logic                  stall,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ack,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  instr_valid,
   output logic [DATA_WIDTH-1:0] InstrD,
   output logic [ADDR_WIDTH-1:0] PCD,
   output logic [ADDR_WIDTH-1:0] PCPlus4D
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic {REQ = 1'b0, DROP = 1'b1} fetchState;

   fetchState             state, stateNext;
   logic [ADDR_WIDTH-1:0] fetchPc, redirectAligned;
   logic [ENTRY_W-1:0]    entries [DEPTH];
   logic [PTR_W-1:0]      rdPtr, wrPtr;
   logic [CNT_W-1:0]      count;
   logic                  reqHeld, reqHeldNext;
   logic                  pop, space, push;

   // Request is gated by rst so the port is quiet for the whole reset window.
   always_comb begin
      stateNext = state;
      imem_req = 1'b0;
      push = 1'b0;
      reqHeldNext = 1'b0;
      pop = instr_valid & ~stall & ~redirect;
      space = (count < FULL_CNT) | pop;
      case (state)
         REQ: begin
            imem_req = rst & (space | reqHeld);
            if (redirect) begin
               if (imem_req & ~imem_ack) stateNext = DROP;
            end else begin
               push = imem_req & imem_ack;
               reqHeldNext = imem_req & ~imem_ack;
            end
         end
         DROP: begin
            if (imem_ack) stateNext = REQ;
         end
         default: stateNext = REQ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= REQ;
         reqHeld <= 1'b0;
         fetchPc <= RESET_PC;
      end else begin
         state <= stateNext;
         reqHeld <= reqHeldNext;
         if (redirect) fetchPc <= redirectAligned;
         else if (push) fetchPc <= fetchPc + ADDR_WIDTH'(4);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else if (redirect) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + PTR_W'(1);
         if (pop) rdPtr <= rdPtr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      end else if (push) begin
         entries[wrPtr] <= {fetchPc, imem_rdata};
      end
   end

   assign redirectAligned = redirect_pc & ~ADDR_WIDTH'(3);
   assign imem_addr = fetchPc;
   assign instr_valid = (count != '0);
   assign {PCD, InstrD} = entries[rdPtr];
   assign PCPlus4D = PCD + ADDR_WIDTH'(4);
endmodule
